// File: rtl/mc_main_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM: opcodes, ALUOp codes,
// FSM states, decode classes and datapath select values.
package mc_main_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp codes understood by ALUControl
  typedef enum logic [3:0] {
    ALUOP_LS    = 4'd0,
    ALUOP_RTYPE = 4'd1,
    ALUOP_BEQ   = 4'd2,
    ALUOP_BNE   = 4'd3,
    ALUOP_ADDI  = 4'd4,
    ALUOP_ANDI  = 4'd5,
    ALUOP_ORI   = 4'd6,
    ALUOP_XORI  = 4'd7,
    ALUOP_SLTI  = 4'd8,
    ALUOP_SLTIU = 4'd9,
    ALUOP_LUI   = 4'd10
  } aluop_e;

  // FSM states; TRAP is only reachable with the trap feature built in
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RTWB   = 4'd7,
    ST_IEXEC  = 4'd8,
    ST_IWB    = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_JAL    = 4'd12,
    ST_TRAP   = 4'd13
  } state_e;

  // Instruction class produced by the opcode decoder
  typedef enum logic [2:0] {
    CL_RTYPE  = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_IMM    = 3'd3,
    CL_BRANCH = 3'd4,
    CL_JUMP   = 3'd5,
    CL_JAL    = 3'd6,
    CL_UNDEF  = 3'd7
  } op_class_e;

  // Datapath select encodings
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] REGDST_RT    = 2'd0;
  localparam logic [1:0] REGDST_RD    = 2'd1;
  localparam logic [1:0] REGDST_RA    = 2'd2;
  localparam logic [1:0] M2R_ALUOUT   = 2'd0;
  localparam logic [1:0] M2R_MDR      = 2'd1;
  localparam logic [1:0] M2R_PC       = 2'd2;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;

  // Waiting states are the ones that stall on mem_ready
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Control bus between the main control FSM and the multi-cycle datapath.
// master: the controller; slave: the datapath/memory side.
interface mc_main_ctrl_if;
  import mc_main_ctrl_pkg::*;

  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] PCSource;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/mc_main_ctrl_op_decode.sv
// Combinational opcode decoder: Op -> instruction class and I-type ALUOp.
// Used both for the DECODE dispatch and for the IEXEC/IWB ALUOp.
module mc_op_decode
  import mc_main_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output op_class_e  op_class,
  output aluop_e     imm_aluop
);

  // Classify the opcode and pick the immediate-op ALU function
  always_comb begin
    op_class  = CL_UNDEF;
    imm_aluop = ALUOP_LS;
    unique case (op)
      OP_RTYPE: op_class = CL_RTYPE;
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: op_class = CL_LOAD;
      OP_SW, OP_SB, OP_SH: op_class = CL_STORE;
      OP_ADDI, OP_ADDIU: begin op_class = CL_IMM; imm_aluop = ALUOP_ADDI;  end
      OP_ANDI:           begin op_class = CL_IMM; imm_aluop = ALUOP_ANDI;  end
      OP_ORI:            begin op_class = CL_IMM; imm_aluop = ALUOP_ORI;   end
      OP_XORI:           begin op_class = CL_IMM; imm_aluop = ALUOP_XORI;  end
      OP_SLTI:           begin op_class = CL_IMM; imm_aluop = ALUOP_SLTI;  end
      OP_SLTIU:          begin op_class = CL_IMM; imm_aluop = ALUOP_SLTIU; end
      OP_LUI:            begin op_class = CL_IMM; imm_aluop = ALUOP_LUI;   end
      OP_BEQ, OP_BNE: op_class = CL_BRANCH;
      OP_J:           op_class = CL_JUMP;
      OP_JAL:         op_class = CL_JAL;
      default:        op_class = CL_UNDEF;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM. Moore outputs decoded from state; only
// PCWrite/IRWrite are qualified by mem_ready (FETCH) or Zero (BRANCH).
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (undefined-op and
// mem_ready-timeout trap with sticky illegal flag; WAIT_MAX exists only then).
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
#(
  parameter int unsigned ST_W = 4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  , parameter int unsigned WAIT_MAX = 15
`endif
) (
  input  logic             clk,
  input  logic             rst,
  mc_main_ctrl_if.master   bus,
  output logic [ST_W-1:0]  state_o,
  output logic             illegal
);

  state_e    state, state_n;
  op_class_e op_class;
  aluop_e    imm_aluop;
  aluop_e    alu_op;
  logic      pc_write, ir_write, ior_d, mem_read, mem_write, reg_write;
  logic      alu_src_a;
  logic [1:0] reg_dst, memto_reg, alu_src_b, pc_source;

  mc_op_decode u_op_decode (
    .op        (bus.Op),
    .op_class  (op_class),
    .imm_aluop (imm_aluop)
  );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam int unsigned CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt;
  logic          wait_expired;
  assign wait_expired = is_mem_wait(state) && !bus.mem_ready && (wait_cnt >= CW'(WAIT_MAX));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_n;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_n   = state;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    ior_d     = IORD_PC;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = REGDST_RT;
    memto_reg = M2R_ALUOUT;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_B;
    alu_op    = ALUOP_LS;
    pc_source = PCSRC_ALU;
    unique case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = bus.mem_ready;
        ir_write  = bus.mem_ready;
        if (bus.mem_ready) state_n = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        unique case (op_class)
          CL_RTYPE:          state_n = ST_EXEC;
          CL_LOAD, CL_STORE: state_n = ST_MEMADR;
          CL_IMM:            state_n = ST_IEXEC;
          CL_BRANCH:         state_n = ST_BRANCH;
          CL_JUMP:           state_n = ST_JUMP;
          CL_JAL:            state_n = ST_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           state_n = ST_TRAP;
`else
          default:           state_n = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_n   = (op_class == CL_LOAD) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        ior_d    = IORD_ALUOUT;
        mem_read = 1'b1;
        if (bus.mem_ready) state_n = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
        memto_reg = M2R_MDR;
        state_n   = ST_FETCH;
      end
      ST_MEMWR: begin
        ior_d     = IORD_ALUOUT;
        mem_write = 1'b1;
        if (bus.mem_ready) state_n = ST_FETCH;
      end
      ST_EXEC: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALUOP_RTYPE;
        state_n   = ST_RTWB;
      end
      ST_RTWB: begin
        // ALUOp stays R-type so ALUControl keeps jr/jalr PC and link selects valid
        reg_write = 1'b1;
        reg_dst   = REGDST_RD;
        memto_reg = M2R_ALUOUT;
        alu_op    = ALUOP_RTYPE;
        state_n   = ST_FETCH;
      end
      ST_IEXEC: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_aluop;
        state_n   = ST_IWB;
      end
      ST_IWB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
        memto_reg = M2R_ALUOUT;
        alu_op    = imm_aluop;
        state_n   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        pc_source = PCSRC_ALUOUT;
        if (bus.Op == OP_BNE) begin
          alu_op   = ALUOP_BNE;
          pc_write = !bus.Zero;
        end else begin
          alu_op   = ALUOP_BEQ;
          pc_write = bus.Zero;
        end
        state_n = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_n   = ST_FETCH;
      end
      ST_JAL: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        reg_write = 1'b1;
        reg_dst   = REGDST_RA;
        memto_reg = M2R_PC;
        state_n   = ST_FETCH;
      end
      ST_TRAP: state_n = ST_TRAP;
      default: state_n = ST_FETCH;
    endcase
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (wait_expired) state_n = ST_TRAP;
`endif
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  // Sticky trap flag and consecutive not-ready cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state_n == ST_TRAP) illegal <= 1'b1;
      if (is_mem_wait(state) && !bus.mem_ready && !wait_expired) wait_cnt <= wait_cnt + 1'b1;
      else                                                        wait_cnt <= '0;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  // Write/request enables are suppressed while rst is held so an aborted
  // instruction cannot commit anything in the reset cycle
  assign bus.PCWrite  = pc_write  & ~rst;
  assign bus.IRWrite  = ir_write  & ~rst;
  assign bus.MemRead  = mem_read  & ~rst;
  assign bus.MemWrite = mem_write & ~rst;
  assign bus.RegWrite = reg_write & ~rst;
  assign bus.IorD     = ior_d;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = memto_reg;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.PCSource = pc_source;
  assign state_o      = ST_W'(state);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl.
module tb_mc_main_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RTWB = 4'd7,
                         S_IEXEC = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_JAL = 4'd12, S_TRAP = 4'd13;
  localparam logic [3:0] A_LS = 4'd0, A_RTYPE = 4'd1, A_BEQ = 4'd2, A_BNE = 4'd3, A_ORI = 4'd6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_o;
  logic       illegal;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned wb_cnt  = 0;
  int          n;

  mc_main_ctrl_if bus ();

  mc_main_ctrl #(.ST_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Count load write-back cycles mid-cycle
  always @(negedge clk) if (bus.RegWrite === 1'b1 && bus.MemtoReg === 2'd1) wb_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until FETCH is re-entered; returns cycles taken
  task automatic run_to_fetch(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (state_o !== S_FETCH && cycles < 30);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic zero, input int exp_len);
    int c;
    bus.Op = op; bus.Zero = zero; bus.mem_ready = 1'b1;
    run_to_fetch(c);
    chk(tag, 32'(c), 32'(exp_len));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.Op = 6'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;

    // Reset: enables gated even though state is FETCH and mem_ready=1
    tick();
    chk("rst_state", 32'(state_o), 32'(S_FETCH));
    chk("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    chk("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    chk("rst_memread", 32'(bus.MemRead), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    tick();
    rst = 1'b0; #1;
    chk("rel_state", 32'(state_o), 32'(S_FETCH));
    chk("rel_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("rel_irwrite", 32'(bus.IRWrite), 32'd1);
    chk("rel_memread", 32'(bus.MemRead), 32'd1);
    chk("rel_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    chk("rel_aluop", 32'(bus.ALUOp), 32'(A_LS));
    bus.mem_ready = 1'b0; #1;
    chk("fetch_stall_pcwrite", 32'(bus.PCWrite), 32'd0);
    tick();
    chk("fetch_stall_state", 32'(state_o), 32'(S_FETCH));
    bus.mem_ready = 1'b1;

    // lw with 3 not-ready cycles in MEMRD: 8 cycles total
    wb_cnt = 0;
    bus.Op = 6'b100011;
    tick();
    chk("lw_decode", 32'(state_o), 32'(S_DECODE));
    chk("lw_decode_srcb", 32'(bus.ALUSrcB), 32'd3);
    tick();
    chk("lw_memadr", 32'(state_o), 32'(S_MEMADR));
    chk("lw_memadr_srca", 32'(bus.ALUSrcA), 32'd1);
    chk("lw_memadr_srcb", 32'(bus.ALUSrcB), 32'd2);
    bus.mem_ready = 1'b0;
    tick();
    chk("lw_memrd1", 32'(state_o), 32'(S_MEMRD));
    chk("lw_memrd_read", 32'(bus.MemRead), 32'd1);
    chk("lw_memrd_iord", 32'(bus.IorD), 32'd1);
    tick();
    chk("lw_memrd2", 32'(state_o), 32'(S_MEMRD));
    tick();
    chk("lw_memrd3", 32'(state_o), 32'(S_MEMRD));
    tick();
    chk("lw_memrd4", 32'(state_o), 32'(S_MEMRD));
    bus.mem_ready = 1'b1;
    tick();
    chk("lw_memwb", 32'(state_o), 32'(S_MEMWB));
    chk("lw_memwb_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("lw_memwb_memtoreg", 32'(bus.MemtoReg), 32'd1);
    chk("lw_memwb_regdst", 32'(bus.RegDst), 32'd0);
    run_to_fetch(n);
    chk("lw_stall_len", 32'(7 + n), 32'd8);
    chk("lw_wb_once", 32'(wb_cnt), 32'd1);

    // Latencies with mem_ready always high
    run_instr("lat_lw", 6'b100011, 1'b0, 5);
    run_instr("lat_sw", 6'b101011, 1'b0, 4);
    run_instr("lat_rtype", 6'b000000, 1'b0, 4);
    run_instr("lat_addi", 6'b001000, 1'b0, 4);
    run_instr("lat_j", 6'b000010, 1'b0, 3);
    run_instr("lat_beq", 6'b000100, 1'b0, 3);

    // R-type execute/write-back
    bus.Op = 6'b000000;
    tick(); tick();
    chk("r_exec", 32'(state_o), 32'(S_EXEC));
    chk("r_exec_aluop", 32'(bus.ALUOp), 32'(A_RTYPE));
    tick();
    chk("r_rtwb", 32'(state_o), 32'(S_RTWB));
    chk("r_rtwb_regdst", 32'(bus.RegDst), 32'd1);
    chk("r_rtwb_aluop", 32'(bus.ALUOp), 32'(A_RTYPE));
    chk("r_rtwb_pcwrite", 32'(bus.PCWrite), 32'd0);
    tick();

    // ori: op-specific ALUOp held through IWB
    bus.Op = 6'b001101;
    tick(); tick();
    chk("ori_iexec", 32'(state_o), 32'(S_IEXEC));
    chk("ori_iexec_aluop", 32'(bus.ALUOp), 32'(A_ORI));
    chk("ori_iexec_srcb", 32'(bus.ALUSrcB), 32'd2);
    tick();
    chk("ori_iwb", 32'(state_o), 32'(S_IWB));
    chk("ori_iwb_aluop", 32'(bus.ALUOp), 32'(A_ORI));
    chk("ori_iwb_regwrite", 32'(bus.RegWrite), 32'd1);
    tick();

    // beq taken, then bne with Zero=1 not taken
    bus.Op = 6'b000100; bus.Zero = 1'b1;
    tick(); tick();
    chk("beq_state", 32'(state_o), 32'(S_BRANCH));
    chk("beq_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("beq_aluop", 32'(bus.ALUOp), 32'(A_BEQ));
    chk("beq_pcsource", 32'(bus.PCSource), 32'd1);
    tick();
    chk("beq_back", 32'(state_o), 32'(S_FETCH));
    bus.Op = 6'b000101;
    tick(); tick();
    chk("bne_state", 32'(state_o), 32'(S_BRANCH));
    chk("bne_pcwrite_z1", 32'(bus.PCWrite), 32'd0);
    chk("bne_aluop", 32'(bus.ALUOp), 32'(A_BNE));
    bus.Zero = 1'b0; #1;
    chk("bne_pcwrite_z0", 32'(bus.PCWrite), 32'd1);
    tick();

    // jal
    bus.Op = 6'b000011;
    tick(); tick();
    chk("jal_state", 32'(state_o), 32'(S_JAL));
    chk("jal_regdst", 32'(bus.RegDst), 32'd2);
    chk("jal_memtoreg", 32'(bus.MemtoReg), 32'd2);
    chk("jal_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("jal_pcsource", 32'(bus.PCSource), 32'd2);
    chk("jal_pcwrite", 32'(bus.PCWrite), 32'd1);
    tick();
    chk("jal_back", 32'(state_o), 32'(S_FETCH));

    // Reset asserted while a store waits in MEMWR
    bus.Op = 6'b101011;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    chk("sw_memwr", 32'(state_o), 32'(S_MEMWR));
    chk("sw_memwrite", 32'(bus.MemWrite), 32'd1);
    rst = 1'b1; #1;
    chk("sw_rst_memwrite", 32'(bus.MemWrite), 32'd0);
    tick();
    chk("sw_rst_state", 32'(state_o), 32'(S_FETCH));
    rst = 1'b0; bus.mem_ready = 1'b1; #1;

    // Undefined opcode
    bus.Op = 6'b111111;
    tick(); tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    chk("ill_state", 32'(state_o), 32'(S_TRAP));
    chk("ill_flag", 32'(illegal), 32'd1);
    tick();
    chk("ill_hold", 32'(state_o), 32'(S_TRAP));
    chk("ill_pcwrite", 32'(bus.PCWrite), 32'd0);
    chk("ill_memread", 32'(bus.MemRead), 32'd0);
    chk("ill_regwrite", 32'(bus.RegWrite), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("ill_cleared", 32'(illegal), 32'd0);
    // mem_ready timeout in FETCH: 15 waits tolerated, 16th traps
    bus.mem_ready = 1'b0;
    repeat (15) tick();
    chk("to_not_yet", 32'(state_o), 32'(S_FETCH));
    tick();
    chk("to_trap", 32'(state_o), 32'(S_TRAP));
    chk("to_flag", 32'(illegal), 32'd1);
`else
    chk("ill_state", 32'(state_o), 32'(S_FETCH));
    chk("ill_flag", 32'(illegal), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
